// File: rtl/peripheral_bus_interconnect_if.sv
// Peripheral bus bundle: core request/response side plus the fan-out to the slave slots.
// The interconnect uses the slave modport; the core and slave models use master.
interface peripheral_bus_interconnect_if #(
    parameter int unsigned NUM_SLAVES = 4
);
    logic                         peripheral_read_request;
    logic                         peripheral_write_request;
    logic [31:0]                  peripheral_addr;
    logic [31:0]                  peripheral_write_data;
    logic                         peripheral_response;
    logic [31:0]                  peripheral_read_data;
    logic [NUM_SLAVES-1:0]        slave_read_request;
    logic [NUM_SLAVES-1:0]        slave_write_request;
    logic [31:0]                  slave_addr;
    logic [31:0]                  slave_write_data;
    logic [NUM_SLAVES-1:0]        slave_response;
    logic [32*NUM_SLAVES-1:0]     slave_read_data;
    logic                         bus_error;
    logic [31:0]                  error_addr;

    modport master (
        output peripheral_read_request, peripheral_write_request, peripheral_addr,
               peripheral_write_data, slave_response, slave_read_data,
        input  peripheral_response, peripheral_read_data, slave_read_request,
               slave_write_request, slave_addr, slave_write_data, bus_error, error_addr
    );

    modport slave (
        input  peripheral_read_request, peripheral_write_request, peripheral_addr,
               peripheral_write_data, slave_response, slave_read_data,
        output peripheral_response, peripheral_read_data, slave_read_request,
               slave_write_request, slave_addr, slave_write_data, bus_error, error_addr
    );
endinterface

// File: rtl/peripheral_bus_interconnect.sv
// Decodes core peripheral requests onto one-hot slave slots, waits for the slave or a
// timeout, and returns a single-cycle response (with bus_error for unmapped/hung slots).
module peripheral_bus_interconnect #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_LSB        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                        clk,
    input logic                        reset,
    peripheral_bus_interconnect_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StRespond, StRelease} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e                state_q;
    logic                  pend_q;
    logic                  write_q;
    logic                  err_q;
    logic [3:0]            sel_q;
    logic [15:0]           cnt_q;
    logic [31:0]           data_q;
    logic                  resp_q;
    logic [31:0]           rdata_q;
    logic [NUM_SLAVES-1:0] sreq_rd_q;
    logic [NUM_SLAVES-1:0] sreq_wr_q;
    logic [31:0]           saddr_q;
    logic [31:0]           swdata_q;
    logic                  berr_q;
    logic [31:0]           eaddr_q;

    logic                  req_any;
    logic                  mapped;
    logic                  sel_resp;
    logic [31:0]           sel_rdata;
    logic [NUM_SLAVES-1:0] sel_onehot;

    assign req_any = bus.peripheral_read_request | bus.peripheral_write_request;
    assign mapped  = 32'(sel_q) < NUM_SLAVES;

    // Only the selected slot's response and data are looked at.
    always_comb begin
        sel_resp   = 1'b0;
        sel_rdata  = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == 4'(i)) begin
                sel_resp      = bus.slave_response[i];
                sel_rdata     = bus.slave_read_data[32*i +: 32];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pend_q    <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            sreq_rd_q <= '0;
            sreq_wr_q <= '0;
            saddr_q   <= '0;
            swdata_q  <= '0;
            berr_q    <= 1'b0;
            eaddr_q   <= '0;
        end else begin
            resp_q <= 1'b0;
            berr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // First edge latches the request, the second one decodes it.
                    if (pend_q) begin
                        pend_q <= 1'b0;
                        cnt_q  <= '0;
                        if (mapped) begin
                            sreq_rd_q <= write_q ? '0 : sel_onehot;
                            sreq_wr_q <= write_q ? sel_onehot : '0;
                            state_q   <= StAccess;
                        end else begin
                            err_q   <= 1'b1;
                            data_q  <= '0;
                            state_q <= StRespond;
                        end
                    end else if (req_any) begin
                        pend_q   <= 1'b1;
                        saddr_q  <= bus.peripheral_addr;
                        swdata_q <= bus.peripheral_write_data;
                        write_q  <= ~bus.peripheral_read_request;
                        sel_q    <= bus.peripheral_addr[SEL_LSB+3:SEL_LSB];
                        err_q    <= 1'b0;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (sel_resp) begin
                        data_q    <= write_q ? '0 : sel_rdata;
                        sreq_rd_q <= '0;
                        sreq_wr_q <= '0;
                        state_q   <= StRespond;
                    end else if (cnt_q == TimeoutLast) begin
                        err_q     <= 1'b1;
                        data_q    <= '0;
                        sreq_rd_q <= '0;
                        sreq_wr_q <= '0;
                        state_q   <= StRespond;
                    end
                end
                StRespond: begin
                    resp_q  <= 1'b1;
                    rdata_q <= err_q ? '0 : data_q;
                    if (err_q) begin
                        berr_q  <= 1'b1;
                        eaddr_q <= saddr_q;
                    end
                    state_q <= StRelease;
                end
                StRelease: begin
                    if (!req_any) state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.peripheral_response  = resp_q;
    assign bus.peripheral_read_data = rdata_q;
    assign bus.slave_read_request   = sreq_rd_q;
    assign bus.slave_write_request  = sreq_wr_q;
    assign bus.slave_addr           = saddr_q;
    assign bus.slave_write_data     = swdata_q;
    assign bus.bus_error            = berr_q;
    assign bus.error_addr           = eaddr_q;
endmodule

// File: tb/tb_peripheral_bus_interconnect.sv
// Bench for peripheral_bus_interconnect: directed vector table, randomized accesses
// against a rule-level reference model, plus late-response and mid-access reset sequences.
module tb_peripheral_bus_interconnect;
    localparam int unsigned NS = 4;
    localparam int unsigned T  = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    peripheral_bus_interconnect_if #(.NUM_SLAVES(NS)) bus_if ();

    peripheral_bus_interconnect #(
        .NUM_SLAVES    (NS),
        .SEL_LSB       (16),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        int          delay;  // slave answers in this request cycle (> T: never)
        int          hold;   // cycles the core keeps requesting after the response
        logic [3:0]  spur;   // non-selected slaves pulsing response during the access
        logic [3:0]  e_rd;
        logic [3:0]  e_wr;
        int          e_req;
        logic [31:0] e_rdata;
        bit          e_err;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_eaddr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] sdata,
                                input int delay, input int hold, input logic [3:0] spur,
                                input logic [3:0] e_rd, input logic [3:0] e_wr, input int e_req,
                                input logic [31:0] e_rdata, input bit e_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.sdata = sdata;
        v.delay = delay; v.hold = hold; v.spur = spur;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_req = e_req; v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    // Expected outcome from the decode / timeout rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t       r;
        logic [3:0] sel;
        logic [3:0] onehot;
        r = v;
        sel = v.addr[19:16];
        r.e_rd = '0;
        r.e_wr = '0;
        if (32'(sel) >= NS) begin
            r.e_req = 0; r.e_err = 1'b1; r.e_rdata = '0;
        end else begin
            onehot = 4'b0001 << sel;
            if (v.rd) r.e_rd = onehot;
            else      r.e_wr = onehot;
            if (v.delay <= int'(T)) begin
                r.e_req = v.delay; r.e_err = 1'b0; r.e_rdata = v.rd ? v.sdata : 32'h0;
            end else begin
                r.e_req = int'(T); r.e_err = 1'b1; r.e_rdata = '0;
            end
        end
        return r;
    endfunction

    // Plays core and slaves for one access; called just after a falling edge.
    task automatic run_access(input vec_t v, input string nm);
        int          req_cyc = 0, resp_cnt = 0, resp_c = 0, berr_cnt = 0, multi = 0;
        int          lat, limit;
        logic [3:0]  or_rd = '0, or_wr = '0, reqs;
        logic [31:0] got_rdata = '0, got_saddr = '0, got_swdata = '0;
        logic        got_err = 1'b0;
        lat   = v.e_req + 3;
        limit = lat + v.hold + 6;
        bus_if.peripheral_read_request  = v.rd;
        bus_if.peripheral_write_request = v.wr;
        bus_if.peripheral_addr          = v.addr;
        bus_if.peripheral_write_data    = v.wdata;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            reqs = bus_if.slave_read_request | bus_if.slave_write_request;
            if (reqs != 0) begin
                req_cyc++;
                if ($countones(reqs) != 1) multi++;
                if (req_cyc == 1) begin
                    got_saddr  = bus_if.slave_addr;
                    got_swdata = bus_if.slave_write_data;
                end
            end
            or_rd |= bus_if.slave_read_request;
            or_wr |= bus_if.slave_write_request;
            if (bus_if.peripheral_response) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    resp_c    = c;
                    got_rdata = bus_if.peripheral_read_data;
                    got_err   = bus_if.bus_error;
                end
            end
            if (bus_if.bus_error) berr_cnt++;
            if (resp_cnt > 0 && c >= resp_c + v.hold) begin
                bus_if.peripheral_read_request  = 1'b0;
                bus_if.peripheral_write_request = 1'b0;
            end
            for (int s = 0; s < NS; s++) bus_if.slave_read_data[32*s +: 32] = $urandom;
            bus_if.slave_response = (reqs != 0) ? (v.spur & ~reqs) : 4'b0000;
            if (reqs != 0 && req_cyc == v.delay) begin
                bus_if.slave_response = bus_if.slave_response | reqs;
                for (int s = 0; s < NS; s++)
                    if (reqs[s]) bus_if.slave_read_data[32*s +: 32] = v.sdata;
            end
        end
        bus_if.peripheral_read_request  = 1'b0;
        bus_if.peripheral_write_request = 1'b0;
        bus_if.slave_response           = '0;
        check({nm, "_req_cycles"}, req_cyc, v.e_req);
        check({nm, "_onehot"}, multi, 0);
        check({nm, "_slave_rd"}, 32'(or_rd), 32'(v.e_rd));
        check({nm, "_slave_wr"}, 32'(or_wr), 32'(v.e_wr));
        check({nm, "_resp_count"}, resp_cnt, 1);
        check({nm, "_latency"}, resp_c, lat);
        check({nm, "_rdata"}, got_rdata, v.e_rdata);
        check({nm, "_err"}, 32'(got_err), 32'(v.e_err));
        check({nm, "_err_pulses"}, berr_cnt, v.e_err ? 1 : 0);
        if (v.e_err) exp_eaddr = v.addr;
        check({nm, "_error_addr"}, bus_if.error_addr, exp_eaddr);
        check({nm, "_rdata_held"}, bus_if.peripheral_read_data, v.e_rdata);
        if (v.e_req > 0) check({nm, "_slave_addr"}, got_saddr, v.addr);
        if (v.e_wr != 0) check({nm, "_slave_wdata"}, got_swdata, v.wdata);
    endtask

    vec_t table_v[8];
    vec_t rv;
    int   cnt_a, cnt_b;
    bit   seen;

    initial begin
        table_v[0] = mk(1, 0, 32'h8001_0004, 32'h0, 32'hA5A5_0001, 3, 0, 4'b0000,
                        4'b0010, 4'b0000, 3, 32'hA5A5_0001, 0);
        table_v[1] = mk(0, 1, 32'h8003_0000, 32'h1234_5678, 32'hDEAD_BEEF, 1, 0, 4'b0000,
                        4'b0000, 4'b1000, 1, 32'h0, 0);
        table_v[2] = mk(1, 0, 32'h8005_0000, 32'h0, 32'h1111_1111, 1, 0, 4'b0000,
                        4'b0000, 4'b0000, 0, 32'h0, 1);
        table_v[3] = mk(1, 0, 32'h8000_0000, 32'h0, 32'h2222_2222, 100, 0, 4'b0000,
                        4'b0001, 4'b0000, 8, 32'h0, 1);
        table_v[4] = mk(1, 0, 32'h8002_0010, 32'h0, 32'h3333_0002, 8, 4, 4'b0000,
                        4'b0100, 4'b0000, 8, 32'h3333_0002, 0);
        table_v[5] = mk(1, 1, 32'h8001_0020, 32'h5555_5555, 32'h4444_0001, 2, 1, 4'b0000,
                        4'b0010, 4'b0000, 2, 32'h4444_0001, 0);
        table_v[6] = mk(0, 1, 32'h8002_0000, 32'h6666_6666, 32'h7777_7777, 4, 0, 4'b0001,
                        4'b0000, 4'b0100, 4, 32'h0, 0);
        table_v[7] = mk(0, 1, 32'h800F_0100, 32'h8888_8888, 32'h0, 1, 2, 4'b0000,
                        4'b0000, 4'b0000, 0, 32'h0, 1);

        bus_if.peripheral_read_request  = 1'b0;
        bus_if.peripheral_write_request = 1'b0;
        bus_if.peripheral_addr          = '0;
        bus_if.peripheral_write_data    = '0;
        bus_if.slave_response           = '0;
        bus_if.slave_read_data          = '0;

        #3;
        check("reset_response", 32'(bus_if.peripheral_response), 0);
        check("reset_rdata", bus_if.peripheral_read_data, 0);
        check("reset_slave_rd", 32'(bus_if.slave_read_request), 0);
        check("reset_slave_wr", 32'(bus_if.slave_write_request), 0);
        check("reset_slave_addr", bus_if.slave_addr, 0);
        check("reset_slave_wdata", bus_if.slave_write_data, 0);
        check("reset_bus_error", 32'(bus_if.bus_error), 0);
        check("reset_error_addr", bus_if.error_addr, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_access(table_v[i], $sformatf("row%0d", i));

        // A slot-0 response arriving after the timeout must be ignored.
        run_access(mk(1, 0, 32'h8000_0040, 32'h0, 32'hCAFE_0000, 50, 0, 4'b0000,
                      4'b0001, 4'b0000, 8, 32'h0, 1), "late");
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 6; c++) begin
            bus_if.slave_response = (c < 2) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (bus_if.peripheral_response) cnt_a++;
            if ((bus_if.slave_read_request | bus_if.slave_write_request) != 0) cnt_b++;
        end
        bus_if.slave_response = '0;
        check("late_resp_ignored", cnt_a, 0);
        check("late_no_request", cnt_b, 0);

        for (int i = 0; i < 30; i++) begin
            rv = mk(1'($urandom), 1'b0, 32'h0, $urandom, $urandom, $urandom_range(1, 10),
                    $urandom_range(0, 3), 4'($urandom), 4'b0, 4'b0, 0, 32'h0, 0);
            rv.wr   = rv.rd ? 1'($urandom) : 1'b1;
            rv.addr = {1'b1, 11'($urandom), 4'($urandom_range(0, 6)), 16'($urandom)};
            run_access(model(rv), $sformatf("rand%0d", i));
        end

        // Reset mid-access with a spurious slot-0 response during a slot-2 read.
        bus_if.peripheral_read_request = 1'b1;
        bus_if.peripheral_addr         = 32'h8002_0000;
        bus_if.slave_response          = 4'b0001;
        seen = 1'b0; cnt_a = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus_if.peripheral_response) cnt_a++;
            if (bus_if.slave_read_request != 0) seen = 1'b1;
        end
        check("rst_req_seen", 32'(seen), 1);
        @(negedge clk);
        if (bus_if.peripheral_response) cnt_a++;
        check("rst_spurious_ignored", cnt_a, 0);
        #2 reset = 1'b0;
        #1;
        check("rst_slave_rd", 32'(bus_if.slave_read_request), 0);
        check("rst_slave_addr", bus_if.slave_addr, 0);
        check("rst_error_addr", bus_if.error_addr, 0);
        check("rst_response", 32'(bus_if.peripheral_response), 0);
        bus_if.peripheral_read_request = 1'b0;
        bus_if.slave_response          = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_eaddr = '0;
        cnt_a = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus_if.peripheral_response ||
                (bus_if.slave_read_request | bus_if.slave_write_request) != 0) cnt_a++;
        end
        check("rst_quiet_after", cnt_a, 0);
        run_access(mk(1, 0, 32'h8001_0008, 32'h0, 32'h0BAD_F00D, 2, 0, 4'b0000,
                      4'b0010, 4'b0000, 2, 32'h0BAD_F00D, 0), "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
